// File: rtl/ras_pkg.sv
// rtl/ras_pkg.sv - shared types and constants for the CVA6 return-address stack
package ras_pkg;

   typedef enum logic [1:0] {
      RAS_NOP,
      RAS_PUSH,
      RAS_POP,
      RAS_REPL
   } ras_op_e;

   localparam int unsigned RAS_MIN_DEPTH = 2;

   function automatic ras_op_e ras_decode(input logic push, input logic pop);
      ras_op_e op;
      case ({push, pop})
         2'b10:   op = RAS_PUSH;
         2'b01:   op = RAS_POP;
         2'b11:   op = RAS_REPL;
         default: op = RAS_NOP;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/ras_ckpt_file.sv
// rtl/ras_ckpt_file.sv - checkpoint slots {ptr, count, top} with valid bits and flush-clear
module ras_ckpt_file #(
   parameter int unsigned NR_CKPT = 4,
   parameter int unsigned IDX_W   = 2,
   parameter int unsigned PTR_W   = 2,
   parameter int unsigned CNT_W   = 3,
   parameter int unsigned VLEN    = 64
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             save_i,
   input  logic             restore_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic [PTR_W-1:0] save_ptr_i,
   input  logic [CNT_W-1:0] save_cnt_i,
   input  logic [VLEN-1:0]  save_top_i,
   output logic             rd_valid_o,
   output logic [PTR_W-1:0] rd_ptr_o,
   output logic [CNT_W-1:0] rd_cnt_o,
   output logic [VLEN-1:0]  rd_top_o
);

   typedef struct packed {
      logic [PTR_W-1:0] ptr;
      logic [CNT_W-1:0] cnt;
      logic [VLEN-1:0]  top;
   } slot_t;

   slot_t              r_slot [NR_CKPT];
   logic [NR_CKPT-1:0] r_valid;
   logic               w_idx_ok;
   logic               w_we;
   slot_t              w_rd;

   // Index encodings past NR_CKPT name no slot and read back as invalid.
   if ((1 << IDX_W) > NR_CKPT) begin : g_idx_chk
      assign w_idx_ok = (int'(idx_i) < int'(NR_CKPT));
   end else begin : g_idx_all
      assign w_idx_ok = 1'b1;
   end

   assign w_we       = save_i & ~restore_i & ~flush_i & w_idx_ok;
   assign w_rd       = r_slot[idx_i];
   assign rd_valid_o = w_idx_ok & r_valid[idx_i];
   assign rd_ptr_o   = w_rd.ptr;
   assign rd_cnt_o   = w_rd.cnt;
   assign rd_top_o   = w_rd.top;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid <= '0;
         for (int i = 0; i < int'(NR_CKPT); i++) r_slot[i] <= '0;
      end else if (flush_i) begin
         r_valid <= '0;
      end else if (w_we) begin
         r_valid[idx_i] <= 1'b1;
         r_slot[idx_i]  <= '{ptr: save_ptr_i, cnt: save_cnt_i, top: save_top_i};
      end
   end

endmodule

// File: rtl/cva6_ras_cbuf.sv
// rtl/cva6_ras_cbuf.sv - circular return-address stack with wrap-on-overflow and flush
// Checkpoint save/restore is built only when CVA6_RAS_CKPT_EN is defined.
module cva6_ras_cbuf
   import ras_pkg::*;
#(
   parameter  int unsigned DEPTH   = 4,
   parameter  int unsigned VLEN    = 64,
   parameter  int unsigned NR_CKPT = 4,
   localparam int unsigned PTR_W   = $clog2(DEPTH),
   localparam int unsigned CNT_W   = $clog2(DEPTH + 1),
   localparam int unsigned IDX_W   = (NR_CKPT > 1) ? $clog2(NR_CKPT) : 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [VLEN-1:0]  data_i,
   output logic [VLEN-1:0]  data_o,
   output logic             valid_o,
   output logic             overflow_o,
   input  logic             ckpt_save_i,
   input  logic             ckpt_restore_i,
   input  logic [IDX_W-1:0] ckpt_idx_i
);

   if (DEPTH < RAS_MIN_DEPTH) begin : g_depth_chk
      $error("cva6_ras_cbuf: DEPTH must be at least RAS_MIN_DEPTH");
   end

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

   logic [VLEN-1:0]  r_stack [DEPTH];
   logic [PTR_W-1:0] r_ptr;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;

   ras_op_e          w_op;
   logic [PTR_W-1:0] w_ptr_inc, w_ptr_dec, w_ptr_n, w_waddr;
   logic [CNT_W-1:0] w_cnt_n;
   logic [VLEN-1:0]  w_wdata;
   logic             w_we, w_ovf_n;
   logic             w_restore, w_rst_valid;
   logic [PTR_W-1:0] w_rst_ptr;
   logic [CNT_W-1:0] w_rst_cnt;
   logic [VLEN-1:0]  w_rst_top;

`ifdef CVA6_RAS_CKPT_EN
   assign w_restore = ckpt_restore_i;

   ras_ckpt_file #(
      .NR_CKPT (NR_CKPT),
      .IDX_W   (IDX_W),
      .PTR_W   (PTR_W),
      .CNT_W   (CNT_W),
      .VLEN    (VLEN)
   ) u_ckpt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .flush_i    (flush_i),
      .save_i     (ckpt_save_i),
      .restore_i  (ckpt_restore_i),
      .idx_i      (ckpt_idx_i),
      .save_ptr_i (r_ptr),
      .save_cnt_i (r_cnt),
      .save_top_i (r_stack[r_ptr]),
      .rd_valid_o (w_rst_valid),
      .rd_ptr_o   (w_rst_ptr),
      .rd_cnt_o   (w_rst_cnt),
      .rd_top_o   (w_rst_top)
   );
`else
   logic w_unused_ckpt;
   assign w_unused_ckpt = ^{ckpt_save_i, ckpt_restore_i, ckpt_idx_i};
   assign w_restore     = 1'b0;
   assign w_rst_valid   = 1'b0;
   assign w_rst_ptr     = '0;
   assign w_rst_cnt     = '0;
   assign w_rst_top     = '0;
`endif

   assign w_op      = ras_decode(push_i, pop_i);
   assign w_ptr_inc = (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
   assign w_ptr_dec = (r_ptr == '0) ? PTR_LAST : r_ptr - 1'b1;

   always_comb begin
      w_ptr_n = r_ptr;
      w_cnt_n = r_cnt;
      w_we    = 1'b0;
      w_waddr = r_ptr;
      w_wdata = data_i;
      w_ovf_n = 1'b0;
      if (flush_i) begin
         w_ptr_n = '0;
         w_cnt_n = '0;
      end else if (w_restore) begin
         // An unsaved slot restores to an empty stack.
         if (w_rst_valid) begin
            w_ptr_n = w_rst_ptr;
            w_cnt_n = w_rst_cnt;
            w_we    = 1'b1;
            w_waddr = w_rst_ptr;
            w_wdata = w_rst_top;
         end else begin
            w_ptr_n = '0;
            w_cnt_n = '0;
         end
      end else begin
         case (w_op)
            RAS_PUSH: begin
               w_ptr_n = w_ptr_inc;
               w_we    = 1'b1;
               w_waddr = w_ptr_inc;
               w_ovf_n = (r_cnt == CNT_MAX);
               w_cnt_n = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
            end
            RAS_POP: begin
               if (r_cnt != '0) begin
                  w_ptr_n = w_ptr_dec;
                  w_cnt_n = r_cnt - 1'b1;
               end
            end
            RAS_REPL: begin
               w_we = 1'b1;
               if (r_cnt == '0) w_cnt_n = CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ptr <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) r_stack[i] <= '0;
      end else begin
         r_ptr <= w_ptr_n;
         r_cnt <= w_cnt_n;
         r_ovf <= w_ovf_n;
         if (w_we) r_stack[w_waddr] <= w_wdata;
      end
   end

   assign valid_o    = (r_cnt != '0);
   assign data_o     = valid_o ? r_stack[r_ptr] : '0;
   assign overflow_o = r_ovf;

endmodule

// File: doc/cva6_ras_cbuf.md
# cva6_ras_cbuf

Parametrised return-address stack for the CVA6 frontend branch predictor, generalising the fixed two-entry RAS. It is a circular buffer of DEPTH return addresses with wrap-on-overflow, atomic replace-top for simultaneous push and pop, and flush. Optional checkpoint slots snapshot and repair the stack on mispredict. It sits beside the BTB/BHT in the frontend; the frontend drives push and pop from call/return decode.

## Interface
- DEPTH, 4: stack entries, ≥2, any integer (not necessarily power of two)
- VLEN, 64: return-address width
- NR_CKPT, 4: checkpoint slots, ≥1 (used only with CVA6_RAS_CKPT_EN)
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  empty stack, invalidate all checkpoints
- push_i  in  1  push data_i (call)
- pop_i  in  1  pop top (return)
- data_i  in  VLEN  address to push
- data_o  out  VLEN  top-of-stack address, 0 when !valid_o
- valid_o  out  1  stack non-empty
- overflow_o  out  1  registered pulse: the previous cycle's push overwrote the oldest entry
- ckpt_save_i  in  1  snapshot current state into slot ckpt_idx_i
- ckpt_restore_i  in  1  restore state from slot ckpt_idx_i
- ckpt_idx_i  in  $clog2(NR_CKPT) (min 1)  slot index

## Operation
- State: stack[DEPTH] of VLEN, ptr_q (PTR_W=$clog2(DEPTH)), count_q in 0..DEPTH (width $clog2(DEPTH+1)).
- data_o = stack[ptr_q] gated to 0 when count_q==0; valid_o = (count_q!=0). Both combinational from registers.
- Priority per cycle: flush > restore > push/pop.
- Flush: ptr←0, count←0, all checkpoint valids←0; stack contents untouched.
- Push only: ptr←(ptr+1) mod DEPTH, stack[new ptr]←data_i, count←min(count+1,DEPTH). If count==DEPTH, the oldest entry is overwritten and overflow_o=1 next cycle.
- Pop only: if count>0, ptr←(ptr−1) mod DEPTH, count−1. If count==0, no state change, no error.
- Push and pop: stack[ptr]←data_i, ptr unchanged; count unchanged, except 0→1.
- Save: slot←{ptr_q, count_q, stack[ptr_q]} using pre-update values of that cycle. Slot valid←1. Push/pop in the same cycle still apply.
- Restore, valid slot: ptr←slot.ptr, count←slot.count, stack[slot.ptr]←slot.top. Push/pop that cycle are ignored. Deeper entries are not repaired.
- Restore, invalid slot: behaves as an empty-stack restore (ptr←0, count←0).
- Save in a restore or flush cycle is ignored.
- Wrap arithmetic is explicit compare-and-reset at DEPTH−1/0; no reliance on power-of-two overflow.

## Timing
- All updates take effect on the rising clk_i edge; data_o/valid_o reflect the new state in the following cycle. No read latency beyond that.
- overflow_o is high exactly one cycle after each overflowing push; it is low otherwise.
- Reset (async assert, sync deassert handled upstream): ptr 0, count 0, all stack entries 0, checkpoint slots and valids 0, overflow_o 0, so data_o=0 and valid_o=0.
- Reset mid-operation discards all state immediately.
- No backpressure: every request is accepted every cycle.

## Configuration
- CVA6_RAS_CKPT_EN defined: the checkpoint file is instantiated and save/restore behave as above.
- Not defined: the ckpt_* ports remain but are ignored. No checkpoint storage is generated. Flush, push and pop are unchanged.

## Structure
- ras_pkg holds:
  - ras_op_e {RAS_NOP, RAS_PUSH, RAS_POP, RAS_REPL}, decoded from push_i/pop_i
  - localparam RAS_MIN_DEPTH=2
- The slot record is typedef'd locally, because its widths depend on DEPTH and VLEN.
- Sub-module ras_ckpt_file stores NR_CKPT slots with valid bits and flush-clear. It is instantiated only under CVA6_RAS_CKPT_EN.
- Elaboration assertion: DEPTH≥RAS_MIN_DEPTH.

## Test plan
- DEPTH=4, push 0x100,0x200,0x300 then 3 pops → data_o 0x300,0x200,0x100, then valid_o=0 and data_o=0. A 4th pop leaves state unchanged.
- DEPTH=3, push 0xA,0xB,0xC,0xD → overflow_o=1 one cycle after 0xD; pops return 0xD,0xC,0xB then empty.
- Push 0x10, then push+pop with 0x20 → data_o=0x20, count still 1. Push+pop on empty with 0x30 → valid_o=1, data_o=0x30.
- Push 0x1,0x2; save slot 1; pop; push 0x9; restore slot 1 → data_o=0x2, count 2. Restore invalid slot 3 → valid_o=0.
- Same cycle flush+push 0x55 → empty afterward; a subsequent restore of a previously saved slot → empty (valids cleared).
- Assert rst_ni mid-sequence with 3 entries → valid_o=0, data_o=0, overflow_o=0 immediately. Repeat the checkpoint tests without CVA6_RAS_CKPT_EN → restore has no effect.
